// File: rtl/sensor_conditioner.sv
// +----------------------------------------------------------------------------+
// | Module   : sensor_conditioner                                              |
// | Desc.    : Synchronises and debounces the La Rue / Orchard vehicle loops   |
// |            and the pedestrian button, and latches a pedestrian request     |
// |            until the controller acknowledges it.                           |
// |            Optional stuck-sensor detection: define STUCK_DETECT_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int STUCK_CYCLES    = 64,
  parameter int STUCK_W         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       la_rue_raw,
  input  logic       orchard_raw,
  input  logic       ped_button_n,
  input  logic       ped_ack,
  output logic       la_rue_sensor,
  output logic       orchard_sensor,
  output logic       pedestrian_sensor,
  output logic [1:0] sensor_fault
);

  localparam int               c_NCH     = 3;
  // Channel order: [0] La Rue, [1] Orchard, [2] button (idles high).
  localparam logic [c_NCH-1:0] c_IDLE    = 3'b100;
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  logic [c_NCH-1:0] w_raw;
  logic [c_NCH-1:0] w_stable;
  logic [c_NCH-1:0] w_stable_nxt;

  assign w_raw = {ped_button_n, orchard_raw, la_rue_raw};

  generate
    for (genvar gi = 0; gi < c_NCH; gi++) begin : g_chan
      logic             r_meta;
      logic             r_sync;
      logic             r_stable;
      logic [CNT_W-1:0] r_cnt;
      logic             w_mismatch;
      logic             w_hit;

      assign w_mismatch = (r_sync != r_stable);
      assign w_hit      = w_mismatch && (r_cnt == c_DB_LAST);

      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_meta   <= c_IDLE[gi];
          r_sync   <= c_IDLE[gi];
          r_stable <= c_IDLE[gi];
          r_cnt    <= '0;
        end else begin
          r_meta <= w_raw[gi];
          r_sync <= r_meta;
          if (!w_mismatch) begin
            r_cnt <= '0;
          end else if (w_hit) begin
            r_stable <= r_sync;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_stable[gi]     = r_stable;
      // Value the stable flop takes at the coming edge; lets dependants react on that same edge.
      assign w_stable_nxt[gi] = w_hit ? r_sync : r_stable;
    end
  endgenerate

  assign la_rue_sensor  = w_stable[0];
  assign orchard_sensor = w_stable[1];

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ped_state_t;

  ped_state_t r_ped_state;
  ped_state_t w_ped_state_nxt;
  logic       w_press;

  assign w_press = w_stable[2] & ~w_stable_nxt[2];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ped_state <= ST_IDLE;
    end else begin
      r_ped_state <= w_ped_state_nxt;
    end
  end

  always_comb begin
    w_ped_state_nxt = r_ped_state;
    case (r_ped_state)
      ST_IDLE: begin
        if (w_press) begin
          w_ped_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // A fresh press landing with the acknowledge keeps the request alive.
        if (ped_ack && !w_press) begin
          w_ped_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_ped_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign pedestrian_sensor = (r_ped_state == ST_IDLE);

`ifdef STUCK_DETECT_EN
  localparam logic [STUCK_W-1:0] c_STUCK_MAX  = STUCK_W'(STUCK_CYCLES);
  localparam logic [STUCK_W-1:0] c_STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

  generate
    for (genvar gj = 0; gj < 2; gj++) begin : g_stuck
      logic [STUCK_W-1:0] r_cnt;
      logic               r_fault;

      always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_cnt   <= '0;
          r_fault <= 1'b0;
        end else if (!w_stable_nxt[gj]) begin
          r_cnt   <= '0;
          r_fault <= 1'b0;
        end else if (w_stable[gj] && (r_cnt != c_STUCK_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_STUCK_LAST) begin
            r_fault <= 1'b1;
          end
        end
      end

      assign sensor_fault[gj] = r_fault;
    end
  endgenerate
`else
  logic w_unused_stuck_cfg;

  assign w_unused_stuck_cfg = (^w_stable_nxt[1:0]) | ((STUCK_CYCLES > 0) && (STUCK_W > 0));
  assign sensor_fault       = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_sensor_conditioner                                           |
// | Desc.    : Directed scoreboard bench for sensor_conditioner.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sensor_conditioner;

  localparam int c_B_LA  = 0;
  localparam int c_B_OR  = 1;
  localparam int c_B_PED = 2;
  localparam int c_B_F0  = 3;
  localparam int c_B_F1  = 4;

  logic       clk          = 1'b0;
  logic       reset_n      = 1'b0;
  logic       la_rue_raw   = 1'b0;
  logic       orchard_raw  = 1'b0;
  logic       ped_button_n = 1'b1;
  logic       ped_ack      = 1'b0;
  logic       la_rue_sensor;
  logic       orchard_sensor;
  logic       pedestrian_sensor;
  logic [1:0] sensor_fault;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8),
    .STUCK_CYCLES   (16),
    .STUCK_W        (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .la_rue_raw       (la_rue_raw),
    .orchard_raw      (orchard_raw),
    .ped_button_n     (ped_button_n),
    .ped_ack          (ped_ack),
    .la_rue_sensor    (la_rue_sensor),
    .orchard_sensor   (orchard_sensor),
    .pedestrian_sensor(pedestrian_sensor),
    .sensor_fault     (sensor_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    due;
    int    idx;
    logic  val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic push_exp(input string tag, input int dly, input int idx, input logic val);
    exp_t e;
    e.tag = tag;
    e.due = cyc + dly;
    e.idx = idx;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic push_hold(input string tag, input int from, input int to, input int idx,
                           input logic val);
    for (int d = from; d <= to; d++) begin
      push_exp(tag, d, idx, val);
    end
  endtask

  task automatic check_due();
    logic [4:0] obs;
    obs = {sensor_fault, pedestrian_sensor, orchard_sensor, la_rue_sensor};
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k].due == cyc) begin
        total++;
        assert (obs[exp_q[k].idx] === exp_q[k].val) else begin
          bad++;
          $error("FAIL %s cyc=%0d observed=%b expected=%b", exp_q[k].tag, cyc,
                 obs[exp_q[k].idx], exp_q[k].val);
        end
        exp_q.delete(k);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      check_due();
    end
  endtask

  initial begin
    // Reset held, then idle for 20 cycles.
    tick(3);
    push_exp("rst_la", 0, c_B_LA, 1'b0);
    push_exp("rst_or", 0, c_B_OR, 1'b0);
    push_exp("rst_ped", 0, c_B_PED, 1'b1);
    push_exp("rst_f0", 0, c_B_F0, 1'b0);
    push_exp("rst_f1", 0, c_B_F1, 1'b0);
    check_due();
    reset_n = 1'b1;
    push_hold("idle_la", 1, 20, c_B_LA, 1'b0);
    push_hold("idle_or", 1, 20, c_B_OR, 1'b0);
    push_hold("idle_ped", 1, 20, c_B_PED, 1'b1);
    push_hold("idle_f0", 1, 20, c_B_F0, 1'b0);
    push_hold("idle_f1", 1, 20, c_B_F1, 1'b0);
    tick(20);

    // La Rue debounce latency both directions.
    la_rue_raw = 1'b1;
    push_exp("la_rise_early", 5, c_B_LA, 1'b0);
    push_exp("la_rise", 6, c_B_LA, 1'b1);
    tick(8);
    la_rue_raw = 1'b0;
    push_exp("la_fall_early", 5, c_B_LA, 1'b1);
    push_exp("la_fall", 6, c_B_LA, 1'b0);
    tick(8);

    // Orchard glitches shorter than the debounce window.
    repeat (5) begin
      orchard_raw = 1'b1;
      push_hold("or_glitch_hi", 1, 3, c_B_OR, 1'b0);
      tick(3);
      orchard_raw = 1'b0;
      push_hold("or_glitch_lo", 1, 3, c_B_OR, 1'b0);
      tick(3);
    end
    push_hold("or_quiet", 1, 6, c_B_OR, 1'b0);
    tick(6);

    // Pedestrian press, latch through release, acknowledge.
    ped_button_n = 1'b0;
    push_exp("ped_early", 5, c_B_PED, 1'b1);
    push_exp("ped_req", 6, c_B_PED, 1'b0);
    tick(6);
    ped_button_n = 1'b1;
    push_hold("ped_latched", 1, 10, c_B_PED, 1'b0);
    tick(10);
    ped_ack = 1'b1;
    push_exp("ped_ack_clr", 1, c_B_PED, 1'b1);
    tick(1);
    ped_ack = 1'b0;
    push_hold("ped_idle", 1, 4, c_B_PED, 1'b1);
    tick(4);
    ped_ack = 1'b1;
    push_exp("ack_in_idle", 1, c_B_PED, 1'b1);
    tick(1);
    ped_ack = 1'b0;
    push_hold("ack_idle_hold", 1, 8, c_B_PED, 1'b1);
    tick(8);

    // Repeat press while pending, with acknowledge on the press edge.
    ped_button_n = 1'b0;
    push_exp("ped_req2", 6, c_B_PED, 1'b0);
    tick(6);
    ped_button_n = 1'b1;
    push_hold("ped_rel_pend", 1, 8, c_B_PED, 1'b0);
    tick(8);
    ped_button_n = 1'b0;
    push_hold("press_wins", 1, 12, c_B_PED, 1'b0);
    tick(5);
    ped_ack = 1'b1;
    tick(1);
    ped_ack = 1'b0;
    tick(6);
    ped_ack = 1'b1;
    push_exp("ack_clr2", 1, c_B_PED, 1'b1);
    tick(1);
    ped_ack = 1'b0;
    ped_button_n = 1'b1;
    push_hold("release_no_req", 1, 10, c_B_PED, 1'b1);
    tick(10);

    // Reset while pending and mid La Rue debounce.
    ped_button_n = 1'b0;
    push_exp("ped_req3", 6, c_B_PED, 1'b0);
    tick(6);
    ped_button_n = 1'b1;
    tick(8);
    la_rue_raw = 1'b1;
    push_hold("la_mid", 1, 5, c_B_LA, 1'b0);
    push_hold("ped_pend_pre_rst", 1, 5, c_B_PED, 1'b0);
    tick(5);
    reset_n = 1'b0;
    #1;
    push_exp("rst_mid_la", 0, c_B_LA, 1'b0);
    push_exp("rst_mid_ped", 0, c_B_PED, 1'b1);
    check_due();
    la_rue_raw = 1'b0;
    tick(2);
    reset_n = 1'b1;
    push_hold("post_rst_la", 1, 5, c_B_LA, 1'b0);
    push_hold("post_rst_ped", 1, 5, c_B_PED, 1'b1);
    tick(5);
    la_rue_raw = 1'b1;
    push_exp("la_redb_early", 5, c_B_LA, 1'b0);
    push_exp("la_redb", 6, c_B_LA, 1'b1);
    tick(8);
    la_rue_raw = 1'b0;
    push_exp("la_redb_fall", 6, c_B_LA, 1'b0);
    tick(8);

    // Stuck La Rue loop.
`ifdef STUCK_DETECT_EN
    la_rue_raw = 1'b1;
    push_exp("la_stuck_rise", 6, c_B_LA, 1'b1);
    push_exp("f0_early", 21, c_B_F0, 1'b0);
    push_exp("f0_set", 22, c_B_F0, 1'b1);
    push_hold("f0_held", 23, 30, c_B_F0, 1'b1);
    push_hold("f1_quiet", 1, 30, c_B_F1, 1'b0);
    tick(30);
    la_rue_raw = 1'b0;
    push_exp("f0_before_clr", 5, c_B_F0, 1'b1);
    push_exp("la_before_clr", 5, c_B_LA, 1'b1);
    push_exp("f0_clr", 6, c_B_F0, 1'b0);
    push_exp("la_clr", 6, c_B_LA, 1'b0);
    tick(8);
`else
    la_rue_raw = 1'b1;
    push_exp("la_stuck_rise", 6, c_B_LA, 1'b1);
    push_hold("f0_never", 1, 30, c_B_F0, 1'b0);
    push_hold("f1_never", 1, 30, c_B_F1, 1'b0);
    tick(30);
    la_rue_raw = 1'b0;
    push_exp("la_clr", 6, c_B_LA, 1'b0);
    push_hold("f0_never_clr", 1, 8, c_B_F0, 1'b0);
    tick(8);
`endif

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
